pong_paddle_bank: RTL
=====================

PONG_PADDLE_BANK -- requirements
Module: pong_paddle_bank

Interface
REQ-001 SHALL have parameter NUM_PADDLES, default 2, number of independent paddle channels.
REQ-002 SHALL have parameter POS_W, default 10, width of each paddle position.
REQ-003 SHALL have parameter Y_MIN, default 0, topmost legal position.
REQ-004 SHALL have parameter Y_MAX, default 408, bottommost legal position (480 minus 72-line paddle).
REQ-005 SHALL have parameter STEP, default 4, lines moved per frame tick.
REQ-006 SHALL have parameter DB_CNT, default 500000, stable cycles required to accept a button change (10 ms at 50 MHz).
REQ-007 SHALL have parameter RESET_POS, default (Y_MIN+Y_MAX)/2, position loaded by reset.
REQ-008 SHALL have port CLK_50MHZ, input, 1 bit, single clock; all state on rising edge.
REQ-009 SHALL have port RESET, input, 1 bit, asynchronous, active-low reset.
REQ-010 SHALL have port btn, input, 2*NUM_PADDLES bits, raw asynchronous buttons; bit 2i = up, bit 2i+1 = down, for paddle i.
REQ-011 SHALL have port frame_tick, input, 1 bit, one-cycle pulse once per video frame.
REQ-012 SHALL have port mode, input, 1 bit; 0 = hold-to-move, 1 = one step per press.
REQ-013 SHALL have port pos, output, NUM_PADDLES*POS_W bits, paddle i at bits [i*POS_W +: POS_W].
REQ-014 SHALL have port moving, output, NUM_PADDLES bits, one-cycle pulse when paddle i changed position.
REQ-015 SHALL have port at_limit, output, NUM_PADDLES bits, high while pos[i] equals Y_MIN or Y_MAX.

Function
REQ-016 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 Each synchronized bit SHALL have its own debounce counter. The counter clears while the synchronized value equals the debounced value. The debounced value takes the synchronized value once it has differed for DB_CNT consecutive cycles.
REQ-018 A rising edge of a debounced bit SHALL produce a one-cycle registered press pulse.
REQ-019 In mode 1, a press pulse SHALL set a per-button pending flag. Pending flags SHALL clear on frame_tick and whenever mode=0.
REQ-020 A press pulse coincident with frame_tick SHALL leave its flag set for the next tick; set has priority over clear.
REQ-021 The up/down request for a paddle SHALL be the debounced level in mode 0, and the pending flag in mode 1; mode is sampled on the frame_tick cycle.
REQ-022 On frame_tick with up only: pos SHALL become max(pos-STEP, Y_MIN).
REQ-023 On frame_tick with down only: pos SHALL become min(pos+STEP, Y_MAX).
REQ-024 On frame_tick with both requests or neither: pos SHALL hold.
REQ-025 Position arithmetic SHALL use POS_W+1 bits so that no wrap-around occurs at 0 or 2^POS_W-1.
REQ-026 pos SHALL change only on frame_tick cycles. The new value SHALL be visible the cycle after the tick.
REQ-027 moving[i] SHALL be registered and assert for exactly the cycle after a tick in which pos[i] changed. A clamped no-change SHALL NOT assert it.
REQ-028 at_limit SHALL be decoded combinationally from the pos registers.
REQ-029 Paddle channels SHALL be fully independent; one paddle's buttons never affect another.
REQ-030 Legal parameters SHALL satisfy Y_MIN<=RESET_POS<=Y_MAX<2^POS_W, STEP>=1, DB_CNT>=1; other values are unsupported.

Reset
REQ-031 RESET low SHALL immediately set every pos to RESET_POS.
REQ-032 RESET low SHALL clear moving, synchronizers, debounced values, debounce counters, press pulses and pending flags, regardless of clock.
REQ-033 Release SHALL need no further initialisation. The first frame_tick after release SHALL act on buttons already debounced.
REQ-034 Reset asserted mid-movement SHALL abandon the movement with no partial update.

Verification (DB_CNT=4, other defaults)
REQ-035 Reset scenario: hold RESET low, btn=0 -> pos={204,204}, moving=0, at_limit=0.
REQ-036 Hold-to-move scenario: mode 0, btn[0] held past debounce, then 10 ticks -> pos0=164 with moving0 pulsing after each tick; pos1=204.
REQ-037 Clamp scenario: pos0=404, btn[1] held, 3 ticks -> pos0=408 after the first tick, at_limit0=1, moving0 only after the first tick.
REQ-038 Glitch scenario: btn[0] high for 2 cycles -> no debounced change; pos0 unchanged over 5 ticks.
REQ-039 Step-per-press scenario: mode 1, three debounced up presses between two ticks -> pos0 falls by exactly 4; a press coincident with a tick moves pos0 at the following tick.
REQ-040 Both-buttons and mid-move reset scenario: btn[1:0]=11, tick -> pos0 holds; then RESET low mid-sequence -> pos0=204 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pong_paddle_bank.sv
// Bank of independent Pong paddle controllers.
// Each raw button is synchronized, debounced and edge-detected. Paddle
// positions update only on frame_tick. They can follow the held button level
// (mode 0) or move one step per press (mode 1).
module pong_paddle_bank #(
    parameter int NUM_PADDLES = 2,
    parameter int POS_W       = 10,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 408,
    parameter int STEP        = 4,
    parameter int DB_CNT      = 500000,
    parameter int RESET_POS   = (Y_MIN + Y_MAX) / 2
) (
    input  logic                         CLK_50MHZ,
    input  logic                         RESET,
    input  logic [2*NUM_PADDLES-1:0]     btn,
    input  logic                         frame_tick,
    input  logic                         mode,
    output logic [NUM_PADDLES*POS_W-1:0] pos,
    output logic [NUM_PADDLES-1:0]       moving,
    output logic [NUM_PADDLES-1:0]       at_limit
);

    localparam int NUM_BTN = 2 * NUM_PADDLES;
    localparam int CNT_W   = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    // Position math runs one bit wider so that neither underflow below 0
    // nor overflow above 2^POS_W-1 can wrap before the clamp is applied.
    localparam logic [POS_W-1:0] Y_MIN_P   = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] Y_MAX_P   = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] RESET_P   = POS_W'(RESET_POS);
    localparam logic [POS_W:0]   Y_MAX_E   = (POS_W+1)'(Y_MAX);
    localparam logic [POS_W:0]   STEP_E    = (POS_W+1)'(STEP);
    localparam logic [POS_W:0]   UP_LIMIT  = (POS_W+1)'(Y_MIN + STEP);

    logic [NUM_BTN-1:0] db_vec;
    logic [NUM_BTN-1:0] pend_vec;

    genvar gi;

    // ---------------- per-button input conditioning ----------------
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
        logic             sync1_reg;
        logic             sync2_reg;
        logic             db_reg;
        logic             press_reg;
        logic             pend_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic             db_flip;

        // The debounced value changes on this edge when the synchronized
        // value has already differed for DB_CNT-1 cycles and still differs.
        assign db_flip = (sync2_reg != db_reg) && (cnt_reg == CNT_LAST);

        // Two-flop synchronizer for the raw asynchronous button.
        always_ff @(posedge CLK_50MHZ or negedge RESET) begin
            if (!RESET) begin
                sync1_reg <= 1'b0;
                sync2_reg <= 1'b0;
            end else begin
                sync1_reg <= btn[gi];
                sync2_reg <= sync1_reg;
            end
        end

        // Debounce counter, debounced level and registered rising-edge pulse.
        always_ff @(posedge CLK_50MHZ or negedge RESET) begin
            if (!RESET) begin
                cnt_reg   <= '0;
                db_reg    <= 1'b0;
                press_reg <= 1'b0;
            end else begin
                press_reg <= db_flip & sync2_reg;
                if (sync2_reg == db_reg) begin
                    cnt_reg <= '0;
                end else if (db_flip) begin
                    cnt_reg <= '0;
                    db_reg  <= sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end

        // Pending-press flag for step mode; a new press wins over the clear.
        always_ff @(posedge CLK_50MHZ or negedge RESET) begin
            if (!RESET) begin
                pend_reg <= 1'b0;
            end else if (press_reg && mode) begin
                pend_reg <= 1'b1;
            end else if (frame_tick || !mode) begin
                pend_reg <= 1'b0;
            end
        end

        assign db_vec[gi]   = db_reg;
        assign pend_vec[gi] = pend_reg;
    end

    // ---------------- per-paddle position state ----------------
    for (gi = 0; gi < NUM_PADDLES; gi++) begin : g_pad
        logic [POS_W-1:0] pos_reg;
        logic [POS_W-1:0] pos_next;
        logic             moving_reg;
        logic             up_req;
        logic             dn_req;
        logic [POS_W:0]   pos_ext;

        assign up_req  = mode ? pend_vec[2*gi]   : db_vec[2*gi];
        assign dn_req  = mode ? pend_vec[2*gi+1] : db_vec[2*gi+1];
        assign pos_ext = {1'b0, pos_reg};

        // Candidate position for a tick: clamped step, or hold.
        always_comb begin
            pos_next = pos_reg;
            if (up_req && !dn_req) begin
                pos_next = (pos_ext < UP_LIMIT) ? Y_MIN_P : POS_W'(pos_ext - STEP_E);
            end else if (dn_req && !up_req) begin
                pos_next = ((pos_ext + STEP_E) > Y_MAX_E) ? Y_MAX_P : POS_W'(pos_ext + STEP_E);
            end
        end

        // Position register and its one-cycle change pulse.
        always_ff @(posedge CLK_50MHZ or negedge RESET) begin
            if (!RESET) begin
                pos_reg    <= RESET_P;
                moving_reg <= 1'b0;
            end else if (frame_tick) begin
                pos_reg    <= pos_next;
                moving_reg <= (pos_next != pos_reg);
            end else begin
                moving_reg <= 1'b0;
            end
        end

        assign pos[gi*POS_W +: POS_W] = pos_reg;
        assign moving[gi]             = moving_reg;
        assign at_limit[gi]           = (pos_reg == Y_MIN_P) || (pos_reg == Y_MAX_P);
    end

endmodule
